// File: rtl/serial_negation_unit.sv
// Digit-serial two's-complement negate / abs / ones-complement unit.
// Processes DIGIT bits per cycle, LSB first, with a registered carry between digits.
module serial_negation_unit #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIGIT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [1:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             ovf,
    output logic             zero
);
    localparam int unsigned NUM_DIGITS = WIDTH / DIGIT;
    localparam int unsigned CNT_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_DIGITS - 1);
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] DIGIT_MASK = WIDTH'({DIGIT{1'b1}});

    localparam logic [1:0] MODE_PASS = 2'b00;
    localparam logic [1:0] MODE_NEG  = 2'b01;
    localparam logic [1:0] MODE_ABS  = 2'b10;
    localparam logic [1:0] MODE_ONES = 2'b11;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q;
    logic [WIDTH-1:0] a_q;
    logic [1:0]       mode_q;
    logic             inv_q;
    logic             carry_q;
    logic [CNT_W-1:0] cnt_q;

    logic [31:0]      base;
    logic [DIGIT-1:0] slice_in;
    logic [DIGIT:0]   sum;
    logic [WIDTH-1:0] result_d;
    logic             ovf_d;

    assign in_ready = (state_q == StIdle);

    // Shift/mask slicing keeps the digit index free of part-select width issues.
    always_comb begin
        base     = 32'(cnt_q) * DIGIT;
        slice_in = DIGIT'(a_q >> base);
        sum      = {1'b0, slice_in ^ {DIGIT{inv_q}}} + {{DIGIT{1'b0}}, carry_q};
        result_d = (result & ~(DIGIT_MASK << base)) | (WIDTH'(sum[DIGIT-1:0]) << base);
        ovf_d    = ((mode_q == MODE_NEG) || (mode_q == MODE_ABS && a_q[WIDTH-1]))
                   && (a_q == MOST_NEG);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            a_q       <= '0;
            mode_q    <= MODE_PASS;
            inv_q     <= 1'b0;
            carry_q   <= 1'b0;
            cnt_q     <= '0;
            result    <= '0;
            ovf       <= 1'b0;
            zero      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        a_q     <= a;
                        mode_q  <= mode;
                        cnt_q   <= '0;
                        state_q <= StRun;
                        case (mode)
                            MODE_PASS: begin inv_q <= 1'b0;       carry_q <= 1'b0;       end
                            MODE_NEG:  begin inv_q <= 1'b1;       carry_q <= 1'b1;       end
                            MODE_ABS:  begin inv_q <= a[WIDTH-1]; carry_q <= a[WIDTH-1]; end
                            MODE_ONES: begin inv_q <= 1'b1;       carry_q <= 1'b0;       end
                            default:   begin inv_q <= 1'b0;       carry_q <= 1'b0;       end
                        endcase
                    end
                end
                StRun: begin
                    result  <= result_d;
                    carry_q <= sum[DIGIT];
                    cnt_q   <= cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_CNT) begin
                        state_q   <= StDone;
                        out_valid <= 1'b1;
                        zero      <= (result_d == '0);
                        ovf       <= ovf_d;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        state_q   <= StIdle;
                        out_valid <= 1'b0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_negation_unit.sv
// Directed and sweep bench for serial_negation_unit at 8/2, 4/1 and 16/16 configurations.
module tb_serial_negation_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       iv0 = 0, ir0, ov0, or0 = 0, ovf0, z0;
    logic [7:0] a0 = 0, r0;
    logic [1:0] m0 = 0;
    logic       iv1 = 0, ir1, ov1, or1 = 0, ovf1, z1;
    logic [3:0] a1 = 0, r1;
    logic [1:0] m1 = 0;
    logic        iv2 = 0, ir2, ov2, or2 = 0, ovf2, z2;
    logic [15:0] a2 = 0, r2;
    logic [1:0]  m2 = 0;

    serial_negation_unit #(.WIDTH(8), .DIGIT(2)) u_d8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv0), .in_ready(ir0), .a(a0), .mode(m0),
        .out_valid(ov0), .out_ready(or0), .result(r0), .ovf(ovf0), .zero(z0));
    serial_negation_unit #(.WIDTH(4), .DIGIT(1)) u_d4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .a(a1), .mode(m1),
        .out_valid(ov1), .out_ready(or1), .result(r1), .ovf(ovf1), .zero(z1));
    serial_negation_unit #(.WIDTH(16), .DIGIT(16)) u_d16 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv2), .in_ready(ir2), .a(a2), .mode(m2),
        .out_valid(ov2), .out_ready(or2), .result(r2), .ovf(ovf2), .zero(z2));

    int total = 0;
    int bad = 0;

    task automatic check(input string tag, input logic [19:0] got, input logic [19:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", tag, got, exp);
        end
    endtask

    task automatic set_in(input int sel, input logic v, input logic [15:0] av,
                          input logic [1:0] m);
        case (sel)
            0: begin iv0 = v; a0 = av[7:0]; m0 = m; end
            1: begin iv1 = v; a1 = av[3:0]; m1 = m; end
            default: begin iv2 = v; a2 = av; m2 = m; end
        endcase
    endtask

    task automatic set_ordy(input int sel, input logic v);
        case (sel)
            0: or0 = v;
            1: or1 = v;
            default: or2 = v;
        endcase
    endtask

    // {in_ready, out_valid, ovf, zero, result}
    function automatic logic [19:0] obs(input int sel);
        case (sel)
            0: return {ir0, ov0, ovf0, z0, 8'h00, r0};
            1: return {ir1, ov1, ovf1, z1, 12'h000, r1};
            default: return {ir2, ov2, ovf2, z2, r2};
        endcase
    endfunction

    function automatic int num_digits(input int sel);
        case (sel)
            0: return 4;
            1: return 4;
            default: return 1;
        endcase
    endfunction

    // Golden model: {ovf, result} using plain arithmetic on a w-bit operand.
    function automatic logic [16:0] model(input logic [15:0] av, input logic [1:0] m, input int w);
        logic [15:0] mask, x, neg, r;
        logic msb, o;
        mask = 16'hFFFF >> (16 - w);
        x    = av & mask;
        msb  = x[w-1];
        neg  = (~x + 16'd1) & mask;
        case (m)
            2'b00: r = x;
            2'b01: r = neg;
            2'b10: r = msb ? neg : x;
            default: r = ~x & mask;
        endcase
        o = ((m == 2'b01) || (m == 2'b10 && msb)) && (x == (16'd1 << (w - 1)));
        return {o, r};
    endfunction

    task automatic run_op(input int sel, input logic [15:0] av, input logic [1:0] m,
                          input logic [15:0] exp_r, input logic exp_ovf, input int hold);
        logic [19:0] o;
        logic [19:0] exp_done;
        int n;
        exp_done = {1'b0, 1'b1, exp_ovf, (exp_r == 16'h0), exp_r};
        set_in(sel, 1'b1, av, m);
        o = obs(sel);
        n = 0;
        while (!o[19] && n < 20) begin
            @(posedge clk); #1;
            o = obs(sel);
            n++;
        end
        check($sformatf("accept_ready s%0d", sel), 20'(o[19]), 20'd1);
        @(posedge clk); #1;
        // Scramble the inputs after acceptance; they must not matter.
        set_in(sel, 1'b0, ~av, ~m);
        o = obs(sel);
        check($sformatf("busy s%0d", sel), {18'd0, o[19], o[18]}, 20'd0);
        n = 0;
        while (!o[18] && n < 40) begin
            @(posedge clk); #1;
            o = obs(sel);
            n++;
        end
        check($sformatf("latency s%0d a=%h m=%0d", sel, av, m), 20'(n), 20'(num_digits(sel)));
        check($sformatf("done s%0d a=%h m=%0d", sel, av, m), o, exp_done);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check($sformatf("hold%0d s%0d", i, sel), obs(sel), exp_done);
        end
        set_ordy(sel, 1'b1);
        @(posedge clk); #1;
        set_ordy(sel, 1'b0);
        o = obs(sel);
        check($sformatf("release s%0d", sel), {18'd0, o[19], o[18]}, 20'b10);
    endtask

    typedef struct packed {
        logic [7:0] a;
        logic [1:0] m;
        logic [7:0] r;
        logic       ovf;
    } vec_t;

    vec_t vecs [10] = '{
        '{8'h01, 2'b01, 8'hFF, 1'b0},
        '{8'h80, 2'b01, 8'h80, 1'b1},
        '{8'h00, 2'b01, 8'h00, 1'b0},
        '{8'hF6, 2'b10, 8'h0A, 1'b0},
        '{8'h05, 2'b10, 8'h05, 1'b0},
        '{8'h5A, 2'b00, 8'h5A, 1'b0},
        '{8'h5A, 2'b11, 8'hA5, 1'b0},
        '{8'h80, 2'b10, 8'h80, 1'b1},
        '{8'h80, 2'b11, 8'h7F, 1'b0},
        '{8'h80, 2'b00, 8'h80, 1'b0}
    };

    initial begin
        logic [19:0] o;
        logic [16:0] g;
        logic [15:0] av;
        logic [1:0] m;
        logic seen;

        repeat (3) @(posedge clk);
        #1;
        for (int s = 0; s < 3; s++) check($sformatf("reset s%0d", s), obs(s), 20'h80000);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 10; i++)
            run_op(0, {8'h00, vecs[i].a}, vecs[i].m, {8'h00, vecs[i].r}, vecs[i].ovf, 0);

        // Backpressure, then an immediate follow-up operand.
        run_op(0, 16'h0037, 2'b01, 16'h00C9, 1'b0, 6);
        run_op(0, 16'h0002, 2'b01, 16'h00FE, 1'b0, 0);

        // Reset in the middle of RUN.
        set_in(0, 1'b1, 16'h0001, 2'b01);
        @(posedge clk); #1;
        set_in(0, 1'b0, 16'h0000, 2'b00);
        repeat (2) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("rst_mid", obs(0), 20'h80000);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
            o = obs(0);
            seen = seen | o[18];
        end
        check("rst_no_valid", 20'(seen), 20'd0);
        run_op(0, 16'h0003, 2'b01, 16'h00FD, 1'b0, 0);

        for (int x = 0; x < 16; x++) begin
            for (int k = 0; k < 4; k++) begin
                g = model(16'(x), 2'(k), 4);
                run_op(1, 16'(x), 2'(k), g[15:0], g[16], 0);
            end
        end

        run_op(2, 16'h8000, 2'b01, 16'h8000, 1'b1, 0);
        run_op(2, 16'h0000, 2'b01, 16'h0000, 1'b0, 0);
        run_op(2, 16'hFFFF, 2'b10, 16'h0001, 1'b0, 0);
        for (int i = 0; i < 30; i++) begin
            av = 16'($urandom);
            m  = 2'($urandom_range(0, 3));
            g  = model(av, m, 16);
            run_op(2, av, m, g[15:0], g[16], 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/serial_negation_unit.md
Name: serial_negation_unit

Overview:
Parametrised, digit-serial two's-complement negation/absolute-value unit, and the next generation of the team's combinational four-bit negation block. It generalises the 4-bit negate to WIDTH bits and processes DIGIT bits per cycle, LSB first, with a registered carry. It adds mode select, a valid/ready handshake, and overflow/zero flags. It sits in the ALU datapath as a multi-cycle operand pre-processor and trades area for latency.

Parameters:
WIDTH, 8, operand/result width in bits; must be at least 2.
DIGIT, 2, bits processed per cycle; WIDTH % DIGIT == 0 required; DIGIT == WIDTH gives single-pass operation.
NUM_DIGITS, WIDTH/DIGIT, derived localparam; number of RUN cycles.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset
in_valid  input  1  operand/mode presented
in_ready  output  1  unit can accept (high only in IDLE)
a  input  WIDTH  operand, two's complement
mode  input  2  00 pass, 01 negate, 10 abs, 11 ones-complement
out_valid  output  1  result available
out_ready  input  1  downstream accepts result
result  output  WIDTH  processed value
ovf  output  1  set when negate/abs of most-negative value (1 followed by WIDTH-1 zeros)
zero  output  1  result == 0

Behaviour:
- Reset: already decided. One clock; reset is synchronous and active-low. The ports are named clk and rst_n.
- While rst_n is low at a clk edge: state=IDLE, result=0, ovf=0, zero=0, out_valid=0, internal counter/carry/operand registers=0. in_ready=1 after reset.
- FSM states and transitions:
  - IDLE: in_ready=1.
    - On in_valid&in_ready, latch a and mode. Set inv and carry per the mode table below. Set cnt=0. Go to RUN.
  - Mode table (inv, carry):
    - pass: inv=0, carry=0.
    - negate: inv=1, carry=1.
    - abs: inv=carry=a[WIDTH-1].
    - ones: inv=1, carry=0.
  - RUN: each cycle compute {c, s} = (a_slice[cnt] ^ {DIGIT{inv}}) + carry.
    - Write s into result slice cnt and set carry=c.
    - cnt increments each cycle.
    - After the slice with cnt==NUM_DIGITS-1, go to DONE.
  - DONE: out_valid=1. result, ovf and zero are stable.
    - On out_ready, go to IDLE; out_valid=0 next cycle.
    - Holds indefinitely under backpressure.
- No new operand is accepted in RUN or DONE; in_ready=0 there.
  - Leaving DONE and accepting the next operand takes at least one cycle in IDLE.
- Latency: operand accepted at edge k gives out_valid=1 after edge k+NUM_DIGITS. With defaults, that is 4 cycles.
  - Throughput is one result per NUM_DIGITS+2 cycles when out_ready is held high.
- result is written slice-by-slice in RUN. It is only meaningful while out_valid=1.
- Flag rules:
  - ovf=1 iff mode is negate, or mode is abs with a[WIDTH-1]=1, and a is the most-negative value. In that case result equals a.
  - ovf=0 for pass and ones-complement.
  - zero is computed from the final result and is valid with out_valid.
- Arithmetic: the carry out of the final slice is discarded. Negate of 0 gives 0, with the carry propagating through every digit.
- Changes to a/mode after acceptance have no effect.
- Reset mid-operation (rst_n low in RUN or DONE): abort, discard the partial result, and apply reset values at that edge.
- in_valid while in_ready=0 is ignored. The upstream block holds the operand until in_ready.

Test Plan:
- Defaults, mode=01, a=0x01, out_ready=1 -> out_valid rises exactly 4 cycles after acceptance; result=0xFF, ovf=0, zero=0.
- Defaults, mode=01, a=0x80 -> result=0x80, ovf=1. Mode=01, a=0x00 -> result=0x00, zero=1, ovf=0.
- Defaults, mode=10, a=0xF6 -> result=0x0A. Mode=10, a=0x05 -> 0x05. Mode=00, a=0x5A -> 0x5A. Mode=11, a=0x5A -> 0xA5.
- Backpressure: out_ready=0 for 6 cycles in DONE -> out_valid/result/flags stable, in_ready=0. Raise out_ready -> IDLE, next operand accepted.
- Reset: drop rst_n for one cycle mid-RUN -> all outputs 0, in_ready=1 next cycle, no out_valid for the aborted operand. A fresh op then completes normally.
- Parameter sweep: WIDTH=4/DIGIT=1 and WIDTH=16/DIGIT=16. Run an exhaustive (WIDTH=4) or random operand/mode set -> result equals the golden model, and latency equals NUM_DIGITS.
